// File: rtl/pipeline_control_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipeline_control_unit_pkg                                         |
// | Brief  : State encoding, control bundle type and RUN-mode priority decode  |
// |          shared by the pipeline stall/flush/halt sequencer.                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package pipeline_control_unit_pkg;

  // Sequencer states; the encoding is visible on state_o and is relied on by
  // the top-level halt logic, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } pcu_state_t;

  // Per-stage pipeline controls driven by the sequencer.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_wb_write;
  } pcu_ctrl_t;

  // Everything held, nothing flushed.
  localparam pcu_ctrl_t c_CTRL_NOP  = pcu_ctrl_t'(5'b00000);
  // Normal flow: every register advances, no flush or bubble.
  localparam pcu_ctrl_t c_CTRL_FLOW = pcu_ctrl_t'(5'b11001);

  // RUN-mode decode once memory is known to be ready. A mispredict wins over
  // everything in ID because that instruction is on the wrong path.
  function automatic pcu_ctrl_t run_decode(input logic mispredict,
                                           input logic is_hazard,
                                           input logic halt_req);
    pcu_ctrl_t c;
    c = c_CTRL_FLOW;
    if (mispredict) begin
      c.if_id_flush  = 1'b1;
      c.id_ex_bubble = 1'b1;
    end else if (is_hazard) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_bubble = 1'b1;
    end else if (halt_req) begin
      // ECALL moves on to EX; the younger fetch behind it is squashed.
      c.pc_write     = 1'b0;
      c.if_id_flush  = 1'b1;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipeline_control_unit_if                                          |
// | Brief  : Hazard/status inputs and stage-control/perf outputs of the        |
// |          pipeline control unit.                                            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface pipeline_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             is_hazard;
  logic             mispredict;
  logic             halt_req;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_wb_write;
  logic             is_halted;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             timeout_err;

  // Pipeline side: raises hazards, consumes controls.
  modport master (
    output is_hazard, mispredict, halt_req, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_wb_write,
    input  is_halted, state_o, cycle_count, stall_count, flush_count, timeout_err
  );

  // Control unit side.
  modport slave (
    input  is_hazard, mispredict, halt_req, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_wb_write,
    output is_halted, state_o, cycle_count, stall_count, flush_count, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_control_unit_perf_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipeline_control_unit_perf_counter                                |
// | Brief  : Wrapping event counter with enable and asynchronous clear.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pipeline_control_unit_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; wraps naturally modulo 2**CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipeline_control_unit                                             |
// | Brief  : Stall/flush/halt sequencer for the 5-stage pipeline. Prioritises  |
// |          memory busy, mispredict, load-use hazard and ECALL halt, drains   |
// |          older instructions before halting, and keeps perf counters.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_control_unit_if.slave  bus
);

  localparam int c_DRW = $clog2(DRAIN_CYCLES + 1);
  // One spare code above MEM_TIMEOUT so the increment never wraps.
  localparam int c_BW  = $clog2(MEM_TIMEOUT + 2);

  pcu_state_t       r_state;
  pcu_state_t       w_next_state;
  logic [c_DRW-1:0] r_drain_cnt;
  logic [c_BW-1:0]  r_busy_cnt;
  logic [c_BW-1:0]  w_busy_nxt;
  logic             r_timeout_err;
  logic             r_is_halted;
  pcu_ctrl_t        w_ctrl;
  logic             w_halt_acc;
  logic             w_flush_acc;
  logic             w_stall_inc;
  logic             w_cycle_inc;
  logic             w_waitable;

  // RUN and MEM_WAIT share the same busy handling and, once memory is ready,
  // the same priority decode.
  assign w_waitable = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
  assign w_busy_nxt = r_busy_cnt + c_BW'(1);

  // Next-state and stage-control decode; zero latency from inputs.
  always_comb begin
    w_ctrl       = c_CTRL_NOP;
    w_next_state = r_state;
    w_halt_acc   = 1'b0;
    w_flush_acc  = 1'b0;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (bus.mem_busy) begin
          w_next_state = ST_MEM_WAIT;
        end else begin
          w_ctrl       = run_decode(bus.mispredict, bus.is_hazard, bus.halt_req);
          w_flush_acc  = bus.mispredict;
          w_halt_acc   = !bus.mispredict && !bus.is_hazard && bus.halt_req;
          w_next_state = w_halt_acc ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Front end frozen and squashed; older instructions retire when memory allows.
        w_ctrl.if_id_flush  = 1'b1;
        w_ctrl.id_ex_bubble = 1'b1;
        w_ctrl.ex_wb_write  = !bus.mem_busy;
        if (!bus.mem_busy && (r_drain_cnt == c_DRW'(1))) begin
          w_next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_next_state = ST_HALTED;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
    if (reset) begin
      w_ctrl = c_CTRL_NOP;
    end
  end

  assign w_stall_inc = w_waitable && !w_ctrl.pc_write;
  assign w_cycle_inc = (r_state != ST_HALTED);

  // FSM state, drain countdown, busy streak and sticky timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_busy_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_is_halted   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_is_halted <= (w_next_state == ST_HALTED);

      if (w_halt_acc) begin
        r_drain_cnt <= c_DRW'(DRAIN_CYCLES);
      end else if ((r_state == ST_DRAIN) && !bus.mem_busy) begin
        r_drain_cnt <= r_drain_cnt - c_DRW'(1);
      end

      // The streak includes the RUN cycle that first saw busy, so a busy
      // input held N cycles raises the error after exactly N cycles.
      if (w_waitable && bus.mem_busy) begin
        if (r_busy_cnt < c_BW'(MEM_TIMEOUT)) begin
          r_busy_cnt <= w_busy_nxt;
        end
        if (w_busy_nxt >= c_BW'(MEM_TIMEOUT)) begin
          r_timeout_err <= 1'b1;
        end
      end else begin
        r_busy_cnt <= '0;
      end
    end
  end

  pipeline_control_unit_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_cycle_inc),
    .count (bus.cycle_count)
  );

  pipeline_control_unit_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (bus.stall_count)
  );

  pipeline_control_unit_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_acc),
    .count (bus.flush_count)
  );

  assign bus.pc_write     = w_ctrl.pc_write;
  assign bus.if_id_write  = w_ctrl.if_id_write;
  assign bus.if_id_flush  = w_ctrl.if_id_flush;
  assign bus.id_ex_bubble = w_ctrl.id_ex_bubble;
  assign bus.ex_wb_write  = w_ctrl.ex_wb_write;
  assign bus.is_halted    = r_is_halted;
  assign bus.state_o      = r_state;
  assign bus.timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pipeline_control_unit                                          |
// | Brief  : Scoreboard bench for pipeline_control_unit with a cycle-level     |
// |          behavioural model, directed scenarios and random traffic.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_pipeline_control_unit;

  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(32)) bus ();

  pipeline_control_unit #(
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .CNT_W        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_wb_write;
    bit          is_halted, timeout_err;
    int unsigned state;
    bit [31:0]   cyc, stl, fls;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: mode 0 running, 1 waiting on memory, 2 draining, 3 halted.
  int        m_mode;
  int        m_drain_left;
  int        m_streak;
  bit        m_timeout;
  bit [31:0] m_cyc, m_stl, m_fls;

  task automatic model_reset();
    m_mode = 0; m_drain_left = 0; m_streak = 0; m_timeout = 0;
    m_cyc = 0; m_stl = 0; m_fls = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after the edge, queue what the spec predicts for
  // this cycle, then advance the model across the coming edge.
  task automatic step(input bit r, input bit busy, input bit misp, input bit haz, input bit halt);
    exp_t e;
    bit pc, ifw, fl, bb, ew;
    @(posedge clk);
    #1;
    reset = r; bus.mem_busy = busy; bus.mispredict = misp;
    bus.is_hazard = haz; bus.halt_req = halt;
    pc = 0; ifw = 0; fl = 0; bb = 0; ew = 0;
    if (r) model_reset();
    e.state = m_mode; e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls;
    e.is_halted = (m_mode == 3); e.timeout_err = m_timeout;
    if (!r) begin
      if (m_mode == 2) begin
        fl = 1; bb = 1; ew = !busy;
      end else if (m_mode <= 1 && !busy) begin
        if (misp)      begin pc = 1; ifw = 1; fl = 1; bb = 1; ew = 1; end
        else if (haz)  begin bb = 1; ew = 1; end
        else if (halt) begin ifw = 1; fl = 1; ew = 1; end
        else           begin pc = 1; ifw = 1; ew = 1; end
      end
    end
    e.pc_write = pc; e.if_id_write = ifw; e.if_id_flush = fl;
    e.id_ex_bubble = bb; e.ex_wb_write = ew;
    sb_q.push_back(e);
    if (!r) begin
      if (m_mode != 3) m_cyc++;
      if (m_mode <= 1 && !pc) m_stl++;
      if (m_mode <= 1) begin
        if (busy) begin
          m_streak++;
          if (m_streak >= MEM_TIMEOUT) m_timeout = 1;
          m_mode = 1;
        end else begin
          m_streak = 0;
          m_mode = 0;
          if (misp) m_fls++;
          else if (!haz && halt) begin m_mode = 2; m_drain_left = DRAIN_CYCLES; end
        end
      end else if (m_mode == 2 && !busy) begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 3;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it to the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_write",     bus.pc_write,     e.pc_write);
        check("if_id_write",  bus.if_id_write,  e.if_id_write);
        check("if_id_flush",  bus.if_id_flush,  e.if_id_flush);
        check("id_ex_bubble", bus.id_ex_bubble, e.id_ex_bubble);
        check("ex_wb_write",  bus.ex_wb_write,  e.ex_wb_write);
        check("state_o",      bus.state_o,      e.state);
        check("is_halted",    bus.is_halted,    e.is_halted);
        check("timeout_err",  bus.timeout_err,  e.timeout_err);
        check("cycle_count",  bus.cycle_count,  e.cyc);
        check("stall_count",  bus.stall_count,  e.stl);
        check("flush_count",  bus.flush_count,  e.fls);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_busy = 0; bus.mispredict = 0; bus.is_hazard = 0; bus.halt_req = 0;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Load-use hazard for one cycle, then all three ID/EX events together.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    #1;
    check("direct_stall_after_hazard", bus.stall_count, 32'd1);
    check("direct_flush_after_combo",  bus.flush_count, 32'd1);

    // Halt at cycle 10 with no memory stalls.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 11; i <= 14; i++) step(0, 0, 0, 0, 0);
    #1;
    check("direct_halted_at_14", bus.is_halted, 1'b1);
    check("direct_cycles_at_14", bus.cycle_count, 32'd14);
    step(0, 0, 0, 0, 0);
    #1;
    check("direct_cycles_frozen", bus.cycle_count, 32'd14);

    // Halt at cycle 10, memory busy in drain cycles 12 and 13.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    check("direct_drain_at_15", bus.state_o, 2'd2);
    step(0, 0, 0, 0, 0);
    #1;
    check("direct_halted_at_16", bus.is_halted, 1'b1);

    // Asynchronous reset in the middle of a drain.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1;
    check("direct_async_state", bus.state_o, 2'd0);
    check("direct_async_cycles", bus.cycle_count, 32'd0);
    check("direct_async_exwb", bus.ex_wb_write, 1'b0);

    // Memory busy held for exactly MEM_TIMEOUT cycles.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    check("direct_timeout_set", bus.timeout_err, 1'b1);
    step(0, 0, 0, 0, 0);
    #1;
    check("direct_timeout_run", bus.state_o, 2'd0);
    check("direct_timeout_sticky", bus.timeout_err, 1'b1);

    // Random traffic; occasional resets, and a reset soon after any halt.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rr, b, m, h, q;
      rr = (m_mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      b  = ($urandom_range(0, 99) < 20);
      m  = ($urandom_range(0, 99) < 15);
      h  = ($urandom_range(0, 99) < 20);
      q  = ($urandom_range(0, 99) < 4);
      step(rr, b, m, h, q);
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
